// File: rtl/hand_centroid_pkg.sv
// Shared constants and FSM state type for the hand centroid stage and the frame RAM addressing.
package hand_pkg;
  localparam int COORD_W        = 10;
  localparam int CNT_W          = 19;
  localparam int SUM_W          = 29;
  localparam int DEFAULT_WIDTH  = 640;
  localparam int DEFAULT_HEIGHT = 480;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } cent_state_t;
endpackage

// File: rtl/hand_centroid_if.sv
// Pixel stream in, centroid result out. Optional bounding box signals exist only
// when HAND_CENTROID_BBOX_EN is defined.
interface hand_centroid_if;
  import hand_pkg::*;

  logic               frame_start;
  logic               pixel_valid;
  logic               pixel_bit;
  logic [COORD_W-1:0] hand_x;
  logic [COORD_W-1:0] hand_y;
  logic [CNT_W-1:0]   pixel_total;
  logic               cent_found;
  logic               cent_valid;
  logic               busy;
`ifdef HAND_CENTROID_BBOX_EN
  logic [COORD_W-1:0] bbox_xmin;
  logic [COORD_W-1:0] bbox_xmax;
  logic [COORD_W-1:0] bbox_ymin;
  logic [COORD_W-1:0] bbox_ymax;

  modport master (output frame_start, pixel_valid, pixel_bit,
                  input  hand_x, hand_y, pixel_total, cent_found, cent_valid, busy,
                         bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax);
  modport slave  (input  frame_start, pixel_valid, pixel_bit,
                  output hand_x, hand_y, pixel_total, cent_found, cent_valid, busy,
                         bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax);
`else
  modport master (output frame_start, pixel_valid, pixel_bit,
                  input  hand_x, hand_y, pixel_total, cent_found, cent_valid, busy);
  modport slave  (input  frame_start, pixel_valid, pixel_bit,
                  output hand_x, hand_y, pixel_total, cent_found, cent_valid, busy);
`endif
endinterface

// File: rtl/hand_centroid_seq_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses the cycle after the last bit.
module seq_divider #(
    parameter int N_W = 29,
    parameter int D_W = 19,
    parameter int Q_W = 10
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [Q_W-1:0] quotient
);
    localparam int C_W = $clog2(N_W + 1);

    logic [N_W-1:0] quot;
    logic [D_W-1:0] rem;
    logic [D_W-1:0] dvsr;
    logic [C_W-1:0] count;
    logic           running;
    logic [D_W:0]   rem_shift;
    logic [D_W:0]   trial;

    // A set MSB in trial means the subtraction underflowed and the remainder is restored.
    always_comb begin
        rem_shift = {rem, quot[N_W-1]};
        trial     = rem_shift - {1'b0, dvsr};
    end

    // NOTE: reset is synchronous here, so it lives inside the clocked branch; state uses <= only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            quot    <= '0;
            rem     <= '0;
            dvsr    <= '0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quot    <= dividend;
                rem     <= '0;
                dvsr    <= divisor;
                count   <= C_W'(N_W);
                running <= 1'b1;
            end else if (running) begin
                if (!trial[D_W]) begin
                    rem  <= trial[D_W-1:0];
                    quot <= {quot[N_W-2:0], 1'b1};
                end else begin
                    rem  <= rem_shift[D_W-1:0];
                    quot <= {quot[N_W-2:0], 1'b0};
                end
                count <= count - C_W'(1);
                if (count == C_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient = quot[Q_W-1:0];
endmodule

// File: rtl/hand_centroid.sv
// Per-frame centroid of set pixels in a binarised stream. Defining HAND_CENTROID_BBOX_EN
// adds a bounding box of set pixels published alongside the centroid.
module hand_centroid
    import hand_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int HEIGHT     = DEFAULT_HEIGHT,
    parameter int MIN_PIXELS = 64
) (
    input logic            Clk,
    input logic            Reset,
    hand_centroid_if.slave bus
);
    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(HEIGHT + 1);
    localparam logic [X_W-1:0]   X_LAST  = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_END   = Y_W'(HEIGHT);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [SUM_W-1:0]   sum_x, sum_y;
    logic [CNT_W-1:0]   cnt, snap_cnt;
    logic               first_set;
    cent_state_t        state, state_next;
    logic               div_start, pub_div, pub_short;
    logic               done_x, done_y;
    logic [COORD_W-1:0] q_x, q_y;

    // A strobe coinciding with frame_start is the new frame's pixel at (0,0).
    assign first_set = bus.pixel_valid && bus.pixel_bit;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x     <= '0;
            y     <= '0;
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
        end else if (bus.frame_start) begin
            x     <= bus.pixel_valid ? X_W'(1) : '0;
            y     <= '0;
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= first_set ? CNT_W'(1) : '0;
        end else if (bus.pixel_valid && (y < Y_END)) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
            if (bus.pixel_bit) begin
                sum_x <= sum_x + SUM_W'(x);
                sum_y <= sum_y + SUM_W'(y);
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    seq_divider #(.N_W(SUM_W), .D_W(CNT_W), .Q_W(COORD_W)) u_div_x (
        .Clk(Clk), .Reset(Reset), .start(div_start), .dividend(sum_x),
        .divisor(cnt), .done(done_x), .quotient(q_x)
    );

    seq_divider #(.N_W(SUM_W), .D_W(CNT_W), .Q_W(COORD_W)) u_div_y (
        .Clk(Clk), .Reset(Reset), .start(div_start), .dividend(sum_y),
        .divisor(cnt), .done(done_y), .quotient(q_y)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        pub_div    = 1'b0;
        pub_short  = 1'b0;
        case (state)
            IDLE: if (bus.frame_start) begin
                if (cnt >= MIN_CNT) begin
                    div_start  = 1'b1;
                    state_next = DIV;
                end else begin
                    pub_short  = 1'b1;
                    state_next = DONE;
                end
            end
            DIV: if (done_x && done_y) begin
                pub_div    = 1'b1;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            snap_cnt        <= '0;
            bus.hand_x      <= '0;
            bus.hand_y      <= '0;
            bus.pixel_total <= '0;
            bus.cent_found  <= 1'b0;
            bus.cent_valid  <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.cent_valid <= pub_div || pub_short;
            bus.busy       <= (state_next == DIV);
            if (div_start) snap_cnt <= cnt;
            if (pub_short) begin
                bus.cent_found  <= 1'b0;
                bus.pixel_total <= cnt;
            end
            if (pub_div) begin
                bus.hand_x      <= q_x;
                bus.hand_y      <= q_y;
                bus.cent_found  <= 1'b1;
                bus.pixel_total <= snap_cnt;
            end
        end
    end

`ifdef HAND_CENTROID_BBOX_EN
    logic [COORD_W-1:0] cx, cy;
    logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
    logic [COORD_W-1:0] s_xmin, s_xmax, s_ymin, s_ymax;

    assign cx = COORD_W'(x);
    assign cy = COORD_W'(y);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            xmin <= '1; xmax <= '0; ymin <= '1; ymax <= '0;
            s_xmin <= '0; s_xmax <= '0; s_ymin <= '0; s_ymax <= '0;
            bus.bbox_xmin <= '0; bus.bbox_xmax <= '0;
            bus.bbox_ymin <= '0; bus.bbox_ymax <= '0;
        end else begin
            if (bus.frame_start) begin
                xmin <= first_set ? '0 : '1;
                ymin <= first_set ? '0 : '1;
                xmax <= '0;
                ymax <= '0;
            end else if (bus.pixel_valid && bus.pixel_bit && (y < Y_END)) begin
                if (cx < xmin) xmin <= cx;
                if (cx > xmax) xmax <= cx;
                if (cy < ymin) ymin <= cy;
                if (cy > ymax) ymax <= cy;
            end
            if (div_start) begin
                s_xmin <= xmin; s_xmax <= xmax; s_ymin <= ymin; s_ymax <= ymax;
            end
            if (pub_div) begin
                bus.bbox_xmin <= s_xmin; bus.bbox_xmax <= s_xmax;
                bus.bbox_ymin <= s_ymin; bus.bbox_ymax <= s_ymax;
            end
        end
    end
`endif
endmodule

// File: tb/tb_hand_centroid.sv
// Directed bench on an 8x4 frame: dut_a uses MIN_PIXELS=1, dut_b MIN_PIXELS=4, same stimulus.
module tb_hand_centroid;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   vcnt_a = 0;

  hand_centroid_if if_a ();
  hand_centroid_if if_b ();

  hand_centroid #(.WIDTH(8), .HEIGHT(4), .MIN_PIXELS(1)) dut_a (.Clk(Clk), .Reset(Reset), .bus(if_a));
  hand_centroid #(.WIDTH(8), .HEIGHT(4), .MIN_PIXELS(4)) dut_b (.Clk(Clk), .Reset(Reset), .bus(if_b));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) if (if_a.cent_valid === 1'b1) vcnt_a <= vcnt_a + 1;

  task step();
    @(posedge Clk);
    #1;
  endtask

  task drive(input logic fs, input logic pv, input logic pb);
    if_a.frame_start = fs; if_a.pixel_valid = pv; if_a.pixel_bit = pb;
    if_b.frame_start = fs; if_b.pixel_valid = pv; if_b.pixel_bit = pb;
  endtask

  task send_frame(input logic [39:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, mask[i]);
      step();
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task pulse_fs(input logic with_pixel, output int t);
    t = cyc;
    drive(1'b1, with_pixel, with_pixel);
    step();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task wait_valid(input bit on_b, output int t);
    bit seen;
    seen = 1'b0;
    t = -1000;
    for (int i = 0; i < 64 && !seen; i++) begin
      if ((on_b ? if_b.cent_valid : if_a.cent_valid) === 1'b1) begin
        seen = 1'b1;
        t = cyc;
      end else begin
        step();
      end
    end
  endtask

  task test_reset();
    drive(1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    repeat (3) step();
    Reset = 1'b0;
    step();
    n_cmp++; if (if_a.hand_x !== 10'd0) begin n_err++; $display("FAIL reset_hand_x got=%0d want=0", if_a.hand_x); end
    n_cmp++; if (if_a.hand_y !== 10'd0) begin n_err++; $display("FAIL reset_hand_y got=%0d want=0", if_a.hand_y); end
    n_cmp++; if (if_a.pixel_total !== 19'd0) begin n_err++; $display("FAIL reset_total got=%0d want=0", if_a.pixel_total); end
    n_cmp++; if (if_a.cent_found !== 1'b0) begin n_err++; $display("FAIL reset_found got=%b want=0", if_a.cent_found); end
    n_cmp++; if (if_a.cent_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", if_a.cent_valid); end
    n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", if_a.busy); end
  endtask

  task test_single();
    int t0, t1;
    send_frame(40'h00_0008_0000, 32);
    pulse_fs(1'b0, t0);
    n_cmp++; if (if_a.busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b want=1", if_a.busy); end
    wait_valid(1'b0, t1);
    n_cmp++; if (t1 - t0 !== 31) begin n_err++; $display("FAIL single_latency got=%0d want=31", t1 - t0); end
    n_cmp++; if (if_a.hand_x !== 10'd3) begin n_err++; $display("FAIL single_hand_x got=%0d want=3", if_a.hand_x); end
    n_cmp++; if (if_a.hand_y !== 10'd2) begin n_err++; $display("FAIL single_hand_y got=%0d want=2", if_a.hand_y); end
    n_cmp++; if (if_a.pixel_total !== 19'd1) begin n_err++; $display("FAIL single_total got=%0d want=1", if_a.pixel_total); end
    n_cmp++; if (if_a.cent_found !== 1'b1) begin n_err++; $display("FAIL single_found got=%b want=1", if_a.cent_found); end
    n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_done got=%b want=0", if_a.busy); end
  endtask

  task test_all_set();
    int t0, t1;
    send_frame(40'h00_FFFF_FFFF, 32);
    pulse_fs(1'b0, t0);
    wait_valid(1'b0, t1);
    n_cmp++; if (if_a.hand_x !== 10'd3) begin n_err++; $display("FAIL all_hand_x got=%0d want=3", if_a.hand_x); end
    n_cmp++; if (if_a.hand_y !== 10'd1) begin n_err++; $display("FAIL all_hand_y got=%0d want=1", if_a.hand_y); end
    n_cmp++; if (if_a.pixel_total !== 19'd32) begin n_err++; $display("FAIL all_total got=%0d want=32", if_a.pixel_total); end
    n_cmp++; if (if_b.hand_x !== 10'd3 || if_b.hand_y !== 10'd1) begin n_err++; $display("FAIL all_b_xy got=%0d,%0d want=3,1", if_b.hand_x, if_b.hand_y); end
  endtask

  task test_min_pixels();
    int t0, tb_, ta;
    send_frame(40'h00_E000_0000, 32);
    pulse_fs(1'b0, t0);
    wait_valid(1'b1, tb_);
    n_cmp++; if (tb_ - t0 !== 1) begin n_err++; $display("FAIL min_latency got=%0d want=1", tb_ - t0); end
    n_cmp++; if (if_b.cent_found !== 1'b0) begin n_err++; $display("FAIL min_found got=%b want=0", if_b.cent_found); end
    n_cmp++; if (if_b.pixel_total !== 19'd3) begin n_err++; $display("FAIL min_total got=%0d want=3", if_b.pixel_total); end
    n_cmp++; if (if_b.hand_x !== 10'd3 || if_b.hand_y !== 10'd1) begin n_err++; $display("FAIL min_hold_xy got=%0d,%0d want=3,1", if_b.hand_x, if_b.hand_y); end
    wait_valid(1'b0, ta);
    n_cmp++; if (ta - t0 !== 31) begin n_err++; $display("FAIL min_a_latency got=%0d want=31", ta - t0); end
    n_cmp++; if (if_a.hand_x !== 10'd6 || if_a.hand_y !== 10'd3) begin n_err++; $display("FAIL min_a_xy got=%0d,%0d want=6,3", if_a.hand_x, if_a.hand_y); end
  endtask

  task test_overlap();
    int t0, t1;
    send_frame(40'h00_0000_1000, 32);
    pulse_fs(1'b1, t0);
    wait_valid(1'b0, t1);
    n_cmp++; if (if_a.pixel_total !== 19'd1) begin n_err++; $display("FAIL overlap_total1 got=%0d want=1", if_a.pixel_total); end
    n_cmp++; if (if_a.hand_x !== 10'd4 || if_a.hand_y !== 10'd1) begin n_err++; $display("FAIL overlap_xy1 got=%0d,%0d want=4,1", if_a.hand_x, if_a.hand_y); end
    send_frame(40'h00_0000_0002, 31);
    pulse_fs(1'b0, t0);
    wait_valid(1'b0, t1);
    n_cmp++; if (if_a.pixel_total !== 19'd2) begin n_err++; $display("FAIL overlap_total2 got=%0d want=2", if_a.pixel_total); end
    n_cmp++; if (if_a.hand_x !== 10'd1 || if_a.hand_y !== 10'd0) begin n_err++; $display("FAIL overlap_xy2 got=%0d,%0d want=1,0", if_a.hand_x, if_a.hand_y); end
  endtask

  task test_back_to_back();
    int t0, t2, t1, v0;
    step();
    v0 = vcnt_a;
    send_frame(40'h00_0002_0000, 32);
    pulse_fs(1'b0, t0);
    send_frame(40'hFF_FFFF_FFFF, 9);
    pulse_fs(1'b0, t2);
    n_cmp++; if (t2 - t0 !== 10) begin n_err++; $display("FAIL b2b_spacing got=%0d want=10", t2 - t0); end
    wait_valid(1'b0, t1);
    n_cmp++; if (t1 - t0 !== 31) begin n_err++; $display("FAIL b2b_latency got=%0d want=31", t1 - t0); end
    n_cmp++; if (if_a.hand_x !== 10'd1 || if_a.hand_y !== 10'd2) begin n_err++; $display("FAIL b2b_xy1 got=%0d,%0d want=1,2", if_a.hand_x, if_a.hand_y); end
    send_frame(40'h00_8000_0000, 32);
    pulse_fs(1'b0, t0);
    wait_valid(1'b0, t1);
    n_cmp++; if (t1 - t0 !== 31) begin n_err++; $display("FAIL b2b_latency3 got=%0d want=31", t1 - t0); end
    n_cmp++; if (if_a.hand_x !== 10'd7 || if_a.hand_y !== 10'd3 || if_a.pixel_total !== 19'd1) begin
      n_err++; $display("FAIL b2b_frame3 got=%0d,%0d,%0d want=7,3,1", if_a.hand_x, if_a.hand_y, if_a.pixel_total);
    end
    step();
    n_cmp++; if (vcnt_a - v0 !== 2) begin n_err++; $display("FAIL b2b_pulses got=%0d want=2", vcnt_a - v0); end
  endtask

  task test_overrun();
    int t0, t1;
    send_frame(40'hFF_FFFF_FFFF, 40);
    pulse_fs(1'b0, t0);
    wait_valid(1'b0, t1);
    n_cmp++; if (if_a.pixel_total !== 19'd32) begin n_err++; $display("FAIL overrun_total got=%0d want=32", if_a.pixel_total); end
    n_cmp++; if (if_a.hand_x !== 10'd3 || if_a.hand_y !== 10'd1) begin n_err++; $display("FAIL overrun_xy got=%0d,%0d want=3,1", if_a.hand_x, if_a.hand_y); end
  endtask

  task test_reset_mid_div();
    int t0, v0;
    send_frame(40'h00_0000_0001, 32);
    pulse_fs(1'b0, t0);
    repeat (10) step();
    n_cmp++; if (if_a.busy !== 1'b1) begin n_err++; $display("FAIL middiv_busy got=%b want=1", if_a.busy); end
    Reset = 1'b1;
    repeat (2) step();
    Reset = 1'b0;
    v0 = vcnt_a;
    repeat (40) step();
    n_cmp++; if (vcnt_a !== v0) begin n_err++; $display("FAIL middiv_pulses got=%0d want=%0d", vcnt_a, v0); end
    n_cmp++; if (if_a.hand_x !== 10'd0 || if_a.hand_y !== 10'd0) begin n_err++; $display("FAIL middiv_xy got=%0d,%0d want=0,0", if_a.hand_x, if_a.hand_y); end
    n_cmp++; if (if_a.pixel_total !== 19'd0 || if_a.cent_found !== 1'b0 || if_a.busy !== 1'b0) begin
      n_err++; $display("FAIL middiv_state got=%0d,%b,%b want=0,0,0", if_a.pixel_total, if_a.cent_found, if_a.busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_set();
    test_min_pixels();
    test_overlap();
    test_back_to_back();
    test_overrun();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
